// File: rtl/mem_ctrl.sv
// ----------------------------------------------------------------------------
// mem_ctrl
//
// Shares one byte-wide RAM port between instruction fetch (IF) and the MEM
// stage. Word fetches and LB/LH/LW/LBU/LHU/SB/SH/SW accesses are broken into
// little-endian byte transfers at addr, addr+1, ... (wrapping modulo
// 2^ADDR_W, no alignment check). Load data is reassembled and sign/zero
// extended, and busy tells the pipeline to stall.
//
// Handshake: a requester raises its req together with its request fields.
// The request is taken at the first rising edge where the controller is
// IDLE (MEM wins over IF, IF is refused while flush is high). Its fields are
// latched at that edge and ignored afterwards. Completion is signalled by a
// one-cycle if_done / mem_done pulse; if_data / mem_rdata are valid in that
// cycle and hold their value until that requester's next load completion.
// A flush aborts an IF read at the next edge without any if_done.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   if_req/if_addr/flush  IF word fetch request, address, fetch kill
//   if_data/if_done       fetched word and its completion pulse
//   mem_req/mem_we/mem_size/mem_sign/mem_addr/mem_wdata
//                         MEM-stage load/store request fields
//   mem_rdata/mem_done    extended load data and completion pulse
//   ram_din               RAM read byte, valid the cycle after its address
//   ram_dout/ram_a/ram_wr RAM write byte, byte address, write strobe
//   busy                  high whenever the controller is not IDLE
//
// Timing (E0 = accepting edge, N = byte count, cycle k+1 follows edge Ek)
//   read : ram_a = addr+k in cycle k+1, byte k captured at edge E(k+2),
//          DONE (done pulse + data) in cycle N+2
//   write: ram_a = addr+k, ram_dout = byte k, ram_wr = 1 in cycle k+1,
//          DONE (mem_done) in cycle N+1
// ----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush,
    output logic [XLEN-1:0]   if_data,
    output logic              if_done,
    // MEM stage side
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic              mem_sign,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN-1:0]   mem_rdata,
    output logic              mem_done,
    // RAM side
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    // pipeline stall
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Latched transaction context
    // ------------------------------------------------------------------
    state_t            state_q;
    logic              owner_if_q;  // 1 = serving IF, 0 = serving MEM
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [1:0]        last_q;      // index of the final byte (N-1)
    logic [2:0]        cnt_q;       // edges seen since acceptance, minus one
    logic [XLEN-1:0]   rbuf_q;      // load bytes captured so far

    // ------------------------------------------------------------------
    // Next-value helpers
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   rd_word_d;     // rbuf_q with the byte arriving now merged in
    logic [XLEN-1:0]   load_word_d;   // rd_word_d after sign/zero extension
    logic [ADDR_W-1:0] next_addr_d;   // address of the next byte to issue
    logic [1:0]        wr_sel_d;      // index of the next byte to write
    logic [7:0]        next_wbyte_d;
    logic [2:0]        last_ext_d;    // last_q widened for compares with cnt_q

    // Final byte index for an access size; size 3 behaves as a word.
    function automatic logic [1:0] size_to_last(input logic [1:0] sz);
        logic [1:0] r;
        case (sz)
            2'd0:    r = 2'd0;
            2'd1:    r = 2'd1;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    // Byte and half loads extend from their top bit when signed; words pass.
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] w,
                                                    input logic [1:0]      sz,
                                                    input logic            sgn);
        logic [XLEN-1:0] r;
        case (sz)
            2'd0:    r = {{(XLEN-8){sgn & w[7]}}, w[7:0]};
            2'd1:    r = {{(XLEN-16){sgn & w[15]}}, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        last_ext_d = {1'b0, last_q};

        // The byte on ram_din now belongs to the address issued one cycle
        // earlier, i.e. byte (cnt_q-1). At cnt_q == 0 nothing has arrived.
        rd_word_d = rbuf_q;
        for (int k = 0; k < 4; k++) begin
            if (cnt_q == 3'(k + 1)) begin
                rd_word_d[8*k +: 8] = ram_din;
            end
        end
        load_word_d = extend_load(rd_word_d, size_q, sign_q);

        // Plain modular add: an access starting near the top of the address
        // space continues at address 0.
        next_addr_d  = addr_q + ADDR_W'(cnt_q) + ADDR_W'(1);
        wr_sel_d     = cnt_q[1:0] + 2'd1;
        next_wbyte_d = wdata_q[{wr_sel_d, 3'b000} +: 8];
    end

    // ------------------------------------------------------------------
    // Controller FSM; every output is a register written here.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            owner_if_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= 2'd0;
            sign_q     <= 1'b0;
            last_q     <= 2'd0;
            cnt_q      <= 3'd0;
            rbuf_q     <= '0;
            if_data    <= '0;
            if_done    <= 1'b0;
            mem_rdata  <= '0;
            mem_done   <= 1'b0;
            ram_dout   <= 8'd0;
            ram_a      <= '0;
            ram_wr     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // completion strobes are single-cycle pulses
            if_done  <= 1'b0;
            mem_done <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (mem_req) begin
                        // MEM has priority; a waiting IF simply keeps if_req up.
                        owner_if_q <= 1'b0;
                        addr_q     <= mem_addr;
                        wdata_q    <= mem_wdata;
                        size_q     <= mem_size;
                        sign_q     <= mem_sign;
                        last_q     <= size_to_last(mem_size);
                        cnt_q      <= 3'd0;
                        rbuf_q     <= '0;
                        ram_a      <= mem_addr;
                        busy       <= 1'b1;
                        if (mem_we) begin
                            state_q  <= S_WRITE;
                            ram_wr   <= 1'b1;
                            ram_dout <= mem_wdata[7:0];
                        end else begin
                            state_q  <= S_READ;
                        end
                    end else if (if_req && !flush) begin
                        // Fetches are always full, unextended words.
                        owner_if_q <= 1'b1;
                        addr_q     <= if_addr;
                        wdata_q    <= '0;
                        size_q     <= 2'd2;
                        sign_q     <= 1'b0;
                        last_q     <= 2'd3;
                        cnt_q      <= 3'd0;
                        rbuf_q     <= '0;
                        ram_a      <= if_addr;
                        busy       <= 1'b1;
                        state_q    <= S_READ;
                    end
                end

                S_READ: begin
                    if (owner_if_q && flush) begin
                        // Killed fetch: drop whatever byte is in flight.
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                        ram_a   <= '0;
                    end else begin
                        cnt_q  <= cnt_q + 3'd1;
                        rbuf_q <= rd_word_d;
                        if (cnt_q < last_ext_d) begin
                            ram_a <= next_addr_d;
                        end else if (cnt_q == last_ext_d + 3'd1) begin
                            // Last byte captured at this edge.
                            state_q <= S_DONE;
                            ram_a   <= '0;
                            if (owner_if_q) begin
                                if_data <= rd_word_d;
                                if_done <= 1'b1;
                            end else begin
                                mem_rdata <= load_word_d;
                                mem_done  <= 1'b1;
                            end
                        end
                        // cnt_q == last: latency cycle for the final byte,
                        // ram_a simply holds.
                    end
                end

                S_WRITE: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q < last_ext_d) begin
                        ram_a    <= next_addr_d;
                        ram_dout <= next_wbyte_d;
                    end else begin
                        state_q  <= S_DONE;
                        ram_wr   <= 1'b0;
                        ram_a    <= '0;
                        ram_dout <= 8'd0;
                        mem_done <= 1'b1;
                    end
                end

                S_DONE: begin
                    // One cycle only; no request may be taken here.
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                    ram_wr  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_ctrl
//
// Bench for mem_ctrl. A byte RAM answers the DUT's ram_a/ram_wr. A
// transaction-level model decides at each edge whether a request is taken
// and, if so, lays out the whole expected cycle sequence of that
// transaction (addresses, write bytes, busy, done pulse, result word) in a
// queue; one compare process checks the DUT against the head of that queue
// every cycle. Directed scenarios add hand-computed literal expectations,
// followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_mem_ctrl;

  localparam int AW = 32;
  localparam int XW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          flush = 1'b0;
  logic [XW-1:0] if_data;
  logic          if_done;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [1:0]    mem_size = 2'd0;
  logic          mem_sign = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [XW-1:0] mem_wdata = '0;
  logic [XW-1:0] mem_rdata;
  logic          mem_done;
  logic [7:0]    ram_din = 8'd0;
  logic [7:0]    ram_dout;
  logic [AW-1:0] ram_a;
  logic          ram_wr;
  logic          busy;

  mem_ctrl #(.ADDR_W(AW), .XLEN(XW)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .flush     (flush),
    .if_data   (if_data),
    .if_done   (if_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_size  (mem_size),
    .mem_sign  (mem_sign),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_a     (ram_a),
    .ram_wr    (ram_wr),
    .busy      (busy)
  );

  // check bookkeeping
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------
  // Memories: ram_mem is what the DUT actually reads/writes, model_mem is
  // the model's view. Untouched addresses hold a fixed address hash.
  // ------------------------------------------------------------------
  logic [7:0] ram_mem   [bit [31:0]];
  logic [7:0] model_mem [bit [31:0]];

  function automatic logic [7:0] dflt(input bit [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_rd(input bit [31:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [7:0] mdl_rd(input bit [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return dflt(a);
  endfunction

  task automatic poke(input bit [31:0] a, input logic [7:0] b);
    ram_mem[a]   = b;
    model_mem[a] = b;
  endtask

  // RAM: the address seen in a cycle returns its byte in the next cycle.
  logic [7:0] ram_pend = 8'd0;
  always @(negedge clk) begin
    ram_pend = ram_rd(ram_a);
    if (ram_wr) ram_mem[ram_a] = ram_dout;
  end
  always @(posedge clk) begin
    #1 ram_din = ram_pend;
  end

  // ------------------------------------------------------------------
  // Behavioural model
  // ------------------------------------------------------------------
  typedef struct {
    bit          busy;
    bit          wr;
    bit          a_chk;   // ram_a is defined this cycle
    logic [31:0] a;
    logic [7:0]  dout;
    bit          ifd;     // if_done expected
    bit          md;      // mem_done expected
    bit          upd;     // this done carries a new result word
    logic [31:0] data;
    bit          if_rd;   // cycle belongs to an IF read that flush can kill
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] exp_if_data;
  logic [31:0] exp_mem_rdata;

  function automatic exp_t mk(input bit b, input bit w, input bit ac, input logic [31:0] a,
                              input logic [7:0] d, input bit ifd, input bit md, input bit upd,
                              input logic [31:0] data, input bit ifrd);
    exp_t r;
    r.busy = b; r.wr = w; r.a_chk = ac; r.a = a; r.dout = d;
    r.ifd = ifd; r.md = md; r.upd = upd; r.data = data; r.if_rd = ifrd;
    return r;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'd0) return 1;
    if (sz == 2'd1) return 2;
    return 4;
  endfunction

  task automatic push_read(input logic [31:0] addr, input int n, input bit is_if,
                           input bit sgn);
    logic [31:0] v;
    v = 32'd0;
    for (int k = 0; k < n; k++)
      v = v + (32'(mdl_rd(addr + 32'(k))) << (8 * k));
    if (sgn && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (sgn && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    for (int k = 0; k < n; k++)
      exp_q.push_back(mk(1, 0, 1, addr + 32'(k), 8'd0, 0, 0, 0, 32'd0, is_if));
    exp_q.push_back(mk(1, 0, 0, 32'd0, 8'd0, 0, 0, 0, 32'd0, is_if));
    exp_q.push_back(mk(1, 0, 0, 32'd0, 8'd0, is_if, !is_if, 1, v, 0));
  endtask

  task automatic push_write(input logic [31:0] addr, input int n, input logic [31:0] wd);
    for (int k = 0; k < n; k++) begin
      model_mem[addr + 32'(k)] = wd[8*k +: 8];
      exp_q.push_back(mk(1, 1, 1, addr + 32'(k), wd[8*k +: 8], 0, 0, 0, 32'd0, 0));
    end
    exp_q.push_back(mk(1, 0, 0, 32'd0, 8'd0, 0, 1, 0, 32'd0, 0));
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      cur           = mk(0, 0, 0, 32'd0, 8'd0, 0, 0, 0, 32'd0, 0);
      exp_if_data   = 32'd0;
      exp_mem_rdata = 32'd0;
    end else begin
      if (cur.if_rd && flush) begin
        exp_q.delete();
        cur = mk(0, 0, 0, 32'd0, 8'd0, 0, 0, 0, 32'd0, 0);
      end else if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
      end else if (!cur.busy && mem_req) begin
        if (mem_we) push_write(mem_addr, nbytes(mem_size), mem_wdata);
        else        push_read(mem_addr, nbytes(mem_size), 0, mem_sign);
        cur = exp_q.pop_front();
      end else if (!cur.busy && if_req && !flush) begin
        push_read(if_addr, 4, 1, 0);
        cur = exp_q.pop_front();
      end else begin
        cur = mk(0, 0, 0, 32'd0, 8'd0, 0, 0, 0, 32'd0, 0);
      end
      if (cur.upd) begin
        if (cur.ifd) exp_if_data   = cur.data;
        else         exp_mem_rdata = cur.data;
      end
    end
  end

  // compare process: every cycle, mid-cycle
  always @(negedge clk) begin
    if (rst && cmp_en) begin
      chk("busy",      32'(busy),     32'(cur.busy));
      chk("ram_wr",    32'(ram_wr),   32'(cur.wr));
      chk("if_done",   32'(if_done),  32'(cur.ifd));
      chk("mem_done",  32'(mem_done), 32'(cur.md));
      chk("if_data",   if_data,       exp_if_data);
      chk("mem_rdata", mem_rdata,     exp_mem_rdata);
      if (cur.a_chk) chk("ram_a",    ram_a,          cur.a);
      if (cur.wr)    chk("ram_dout", 32'(ram_dout),  32'(cur.dout));
    end
  end

  // ------------------------------------------------------------------
  // Driver helpers
  // ------------------------------------------------------------------
  task automatic set_mem(input bit we, input logic [1:0] sz, input bit sgn,
                         input logic [31:0] a, input logic [31:0] wd);
    mem_req = 1'b1; mem_we = we; mem_size = sz; mem_sign = sgn;
    mem_addr = a; mem_wdata = wd;
  endtask

  // Runs max_n cycles after the edge that samples the current inputs,
  // dropping requests at the given cycle numbers and recording the cycle
  // of the first done pulse of each kind (0 = no pulse).
  task automatic run(input int drop_mem, input int drop_if, input int max_n,
                     output int n_md, output int n_ifd, output int n_wr);
    n_md = 0; n_ifd = 0; n_wr = 0;
    for (int n = 1; n <= max_n; n++) begin
      @(negedge clk);
      if (mem_done && n_md == 0)  n_md = n;
      if (if_done && n_ifd == 0)  n_ifd = n;
      if (ram_wr) n_wr++;
      if (n == drop_mem) mem_req = 1'b0;
      if (n == drop_if)  if_req  = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
    return 32'h0000_4000 + 32'($urandom_range(0, 15));
  endfunction

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  int n_md, n_ifd, n_wr;

  initial begin
    // reset state
    #23;
    chk("rst_busy",      32'(busy),     32'd0);
    chk("rst_ram_wr",    32'(ram_wr),   32'd0);
    chk("rst_ram_a",     ram_a,         32'd0);
    chk("rst_if_data",   if_data,       32'd0);
    chk("rst_mem_rdata", mem_rdata,     32'd0);
    chk("rst_dones",     32'({if_done, mem_done}), 32'd0);
    @(negedge clk); #2 rst = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // IF fetch 0x100
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
    if_req = 1'b1; if_addr = 32'h100;
    run(0, 1, 9, n_md, n_ifd, n_wr);
    chk("fetch_word",    if_data,   32'h0010_0513);
    chk("fetch_latency", n_ifd,     32'd6);
    chk("fetch_no_wr",   n_wr,      32'd0);

    // simultaneous IF + LB: MEM first, IF right after DONE
    poke(32'h20, 8'h80);
    if_req = 1'b1; if_addr = 32'h100;
    set_mem(0, 2'd0, 1, 32'h20, 32'd0);
    run(1, 5, 13, n_md, n_ifd, n_wr);
    chk("lb_data",       mem_rdata, 32'hFFFF_FF80);
    chk("lb_latency",    n_md,      32'd3);
    chk("if_after_mem",  n_ifd,     32'd10);

    // SW 0xDEADBEEF at 0x1000
    set_mem(1, 2'd2, 0, 32'h1000, 32'hDEAD_BEEF);
    run(1, 0, 8, n_md, n_ifd, n_wr);
    chk("sw_done_cycle", n_md, 32'd5);
    chk("sw_wr_cycles",  n_wr, 32'd4);
    chk("sw_ram_word", {ram_rd(32'h1003), ram_rd(32'h1002), ram_rd(32'h1001), ram_rd(32'h1000)},
        32'hDEAD_BEEF);

    // LHU / LH across the top of the address space
    poke(32'hFFFF_FFFF, 8'h34); poke(32'h0, 8'h12);
    set_mem(0, 2'd1, 0, 32'hFFFF_FFFF, 32'd0);
    run(1, 0, 6, n_md, n_ifd, n_wr);
    chk("lhu_data",    mem_rdata, 32'h0000_1234);
    chk("lhu_latency", n_md,      32'd4);
    poke(32'hFFFF_FFFF, 8'h00); poke(32'h0, 8'h80);
    set_mem(0, 2'd1, 1, 32'hFFFF_FFFF, 32'd0);
    run(1, 0, 6, n_md, n_ifd, n_wr);
    chk("lh_data",     mem_rdata, 32'hFFFF_8000);

    // flush in cycle 2 of a fetch with a LW waiting
    poke(32'h21, 8'h11); poke(32'h22, 8'h22); poke(32'h23, 8'h33);
    if_req = 1'b1; if_addr = 32'h200;
    n_md = 0; n_ifd = 0;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (mem_done && n_md == 0) n_md = n;
      if (if_done) n_ifd++;
      if (n == 3) chk("flush_idle_busy", 32'(busy), 32'd0);
      if (n == 1) begin
        if_req = 1'b0;
        set_mem(0, 2'd2, 0, 32'h20, 32'd0);
      end
      flush = (n == 2);
      if (n == 4) mem_req = 1'b0;
    end
    chk("flush_no_if_done", n_ifd,     32'd0);
    chk("flush_mem_done",   n_md,      32'd9);
    chk("flush_lw_data",    mem_rdata, 32'h3322_1180);

    // asynchronous reset in the middle of a SW
    set_mem(1, 2'd2, 0, 32'h3000, 32'hCAFE_F00D);
    run(1, 0, 3, n_md, n_ifd, n_wr);
    #2 rst = 1'b0;
    #1;
    chk("arst_ram_wr",   32'(ram_wr),   32'd0);
    chk("arst_busy",     32'(busy),     32'd0);
    chk("arst_ram_a",    ram_a,         32'd0);
    chk("arst_mem_done", 32'(mem_done), 32'd0);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    run(0, 0, 6, n_md, n_ifd, n_wr);
    chk("arst_no_done", n_md, 32'd0);
    set_mem(0, 2'd0, 1, 32'h20, 32'd0);
    run(1, 0, 5, n_md, n_ifd, n_wr);
    chk("arst_then_lb", mem_rdata, 32'hFFFF_FF80);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      mem_req   = ($urandom_range(0, 99) < 30);
      mem_we    = $urandom_range(0, 1);
      mem_size  = 2'($urandom_range(0, 3));
      mem_sign  = $urandom_range(0, 1);
      mem_addr  = rand_addr();
      mem_wdata = $urandom;
      if_req    = ($urandom_range(0, 99) < 40);
      if_addr   = rand_addr();
      flush     = ($urandom_range(0, 99) < 6);
    end
    @(negedge clk);
    mem_req = 1'b0; if_req = 1'b0; flush = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
